cpu_prog_loader: RTL and testbench

//  Host-side driver of the CPU external load port. Parses a framed byte stream (e.g. from a UART RX)
//  and writes instruction/data memory through ex_iwe/ex_dwe. On command, releases CPU reset, runs the
//  CPU to halt or timeout, and latches the CPU's Out_R result and cycle count for the host.

---
 rtl/cpu_prog_loader_pkg.sv | 25 ++
 rtl/cpu_prog_loader_if.sv | 46 ++++
 rtl/cpu_prog_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_prog_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_prog_loader_pkg.sv
// Shared definitions for the CPU program loader: command bytes of the host framing protocol
// and the loader FSM state encoding.
package cpu_prog_loader_pkg;

  // Host command bytes (ASCII 'I', 'D', 'R').
  localparam logic [7:0] CMD_I = 8'h49;  // load instruction memory
  localparam logic [7:0] CMD_D = 8'h44;  // load data memory
  localparam logic [7:0] CMD_R = 8'h52;  // run CPU until halt or timeout

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCount,
    StHi,
    StLo,
    StWrite,
    StRun
  } state_e;

  // States in which the loader consumes stream bytes; WRITE and RUN stall the stream.
  function automatic logic accepts_bytes(state_e st);
    return (st != StWrite) && (st != StRun);
  endfunction

endpackage

// File: rtl/cpu_prog_loader_if.sv
// Bundle of all loader-side signals: byte stream in, external memory write port out,
// CPU control/result, and host-visible status.
//   master : the loader (drives rx_ready, ex_*, cpu_rst_n and status)
//   slave  : the environment (drives rx_data/rx_valid and the CPU result inputs)
interface cpu_prog_loader_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) ();

  // Byte stream
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  // Instruction / data memory load port
  logic          ex_iwe;
  logic [AW-1:0] ex_iaddr;
  logic [DW-1:0] ex_idata;
  logic          ex_dwe;
  logic [AW-1:0] ex_daddr;
  logic [DW-1:0] ex_ddata;
  // CPU control and result
  logic          cpu_rst_n;
  logic [DW-1:0] cpu_out_r;
  logic          cpu_done;
  // Host status
  logic          busy;
  logic          run_done;
  logic          timeout;
  logic          cmd_err;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   cycle_count;

  modport master (
    input  rx_data, rx_valid, cpu_out_r, cpu_done,
    output rx_ready, ex_iwe, ex_iaddr, ex_idata, ex_dwe, ex_daddr, ex_ddata, cpu_rst_n,
    output busy, run_done, timeout, cmd_err, out_valid, out_data, cycle_count
  );

  modport slave (
    output rx_data, rx_valid, cpu_out_r, cpu_done,
    input  rx_ready, ex_iwe, ex_iaddr, ex_idata, ex_dwe, ex_daddr, ex_ddata, cpu_rst_n,
    input  busy, run_done, timeout, cmd_err, out_valid, out_data, cycle_count
  );

endinterface

// File: rtl/cpu_prog_loader.sv
// Host-side driver of the CPU external load port. Parses a framed byte stream
//   CMD ['I'|'D'] ADDR COUNT {HI LO}xCOUNT   -> writes instruction or data memory
//   CMD 'R'                                  -> releases CPU reset until halt or timeout
// and latches the CPU's Out_R result and cycle count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cpu_prog_loader_if master modport (stream, memory write port, CPU control,
//                status: busy/run_done/timeout/cmd_err/out_valid/out_data/cycle_count)
// All outputs are registered.
module cpu_prog_loader
  import cpu_prog_loader_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 16'hFFFF,
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_prog_loader_if.master   bus
);

  localparam logic [15:0] LastCycle = 16'(MAX_CYCLES - 1);

  state_e        state_q, state_d;
  logic          rx_ready_q, rx_ready_d;
  logic          sel_dmem_q, sel_dmem_d;    // 1: current frame targets data memory
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    words_q, words_d;          // words remaining, 256 representable
  logic [7:0]    hi_q, hi_d;
  logic          iwe_q, iwe_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [DW-1:0] idata_q, idata_d;
  logic          dwe_q, dwe_d;
  logic [AW-1:0] daddr_q, daddr_d;
  logic [DW-1:0] ddata_q, ddata_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          busy_q, busy_d;
  logic          run_done_q, run_done_d;
  logic          timeout_q, timeout_d;
  logic          cmd_err_q, cmd_err_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [15:0]   cycle_count_q, cycle_count_d;

  logic          take;

  assign take = bus.rx_valid & rx_ready_q;

  always_comb begin
    state_d       = state_q;
    sel_dmem_d    = sel_dmem_q;
    addr_d        = addr_q;
    words_d       = words_q;
    hi_d          = hi_q;
    iwe_d         = 1'b0;
    iaddr_d       = iaddr_q;
    idata_d       = idata_q;
    dwe_d         = 1'b0;
    daddr_d       = daddr_q;
    ddata_d       = ddata_q;
    cpu_rst_n_d   = cpu_rst_n_q;
    run_done_d    = run_done_q;
    timeout_d     = timeout_q;
    cmd_err_d     = cmd_err_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      StIdle: begin
        if (take) begin
          run_done_d = 1'b0;
          timeout_d  = 1'b0;
          cmd_err_d  = 1'b0;
          case (bus.rx_data)
            CMD_I: begin
              sel_dmem_d = 1'b0;
              state_d    = StAddr;
            end
            CMD_D: begin
              sel_dmem_d = 1'b1;
              state_d    = StAddr;
            end
            CMD_R: begin
              cycle_count_d = '0;
              cpu_rst_n_d   = 1'b1;
              state_d       = StRun;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      StAddr: begin
        if (take) begin
          addr_d  = AW'(bus.rx_data);
          state_d = StCount;
        end
      end
      StCount: begin
        if (take) begin
          words_d = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          state_d = StHi;
        end
      end
      StHi: begin
        if (take) begin
          hi_d    = bus.rx_data;
          state_d = StLo;
        end
      end
      StLo: begin
        // Strobe is registered, so it is visible exactly during the WRITE cycle.
        if (take) begin
          if (sel_dmem_q) begin
            dwe_d   = 1'b1;
            daddr_d = addr_q;
            ddata_d = DW'({hi_q, bus.rx_data});
          end else begin
            iwe_d   = 1'b1;
            iaddr_d = addr_q;
            idata_d = DW'({hi_q, bus.rx_data});
          end
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q - 9'd1;
        state_d = (words_q == 9'd1) ? StIdle : StHi;
      end
      StRun: begin
        cycle_count_d = cycle_count_q + 16'd1;
        // A zero Out_R is indistinguishable from "no output" and is ignored.
        if (bus.cpu_out_r != '0) begin
          out_data_d  = bus.cpu_out_r;
          out_valid_d = 1'b1;
        end
        // Halt takes priority over the cycle limit.
        if (bus.cpu_done) begin
          run_done_d  = 1'b1;
          cpu_rst_n_d = 1'b0;
          state_d     = StIdle;
        end else if (cycle_count_q == LastCycle) begin
          timeout_d   = 1'b1;
          cpu_rst_n_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        cpu_rst_n_d = 1'b0;
        state_d     = StIdle;
      end
    endcase

    rx_ready_d = accepts_bytes(state_d);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rx_ready_q    <= 1'b1;
      sel_dmem_q    <= 1'b0;
      addr_q        <= '0;
      words_q       <= '0;
      hi_q          <= '0;
      iwe_q         <= 1'b0;
      iaddr_q       <= '0;
      idata_q       <= '0;
      dwe_q         <= 1'b0;
      daddr_q       <= '0;
      ddata_q       <= '0;
      cpu_rst_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rx_ready_q    <= rx_ready_d;
      sel_dmem_q    <= sel_dmem_d;
      addr_q        <= addr_d;
      words_q       <= words_d;
      hi_q          <= hi_d;
      iwe_q         <= iwe_d;
      iaddr_q       <= iaddr_d;
      idata_q       <= idata_d;
      dwe_q         <= dwe_d;
      daddr_q       <= daddr_d;
      ddata_q       <= ddata_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      timeout_q     <= timeout_d;
      cmd_err_q     <= cmd_err_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.ex_iwe      = iwe_q;
  assign bus.ex_iaddr    = iaddr_q;
  assign bus.ex_idata    = idata_q;
  assign bus.ex_dwe      = dwe_q;
  assign bus.ex_daddr    = daddr_q;
  assign bus.ex_ddata    = ddata_q;
  assign bus.cpu_rst_n   = cpu_rst_n_q;
  assign bus.busy        = busy_q;
  assign bus.run_done    = run_done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader. Two instances: dut_m (default cycle limit) for load and
// run tests, dut_t (MAX_CYCLES=8) for timeout tests. The byte stream is steered to one of them
// by 'sel'; CPU inputs are shared.
module tb_cpu_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] cpu_out_r;
  logic        cpu_done;
  logic        cur_ready;

  int total = 0;
  int bad   = 0;

  cpu_prog_loader_if #(.AW(8), .DW(16)) bus_m ();
  cpu_prog_loader_if #(.AW(8), .DW(16)) bus_t ();

  assign bus_m.rx_data   = rx_data;
  assign bus_m.rx_valid  = rx_valid & ~sel;
  assign bus_m.cpu_out_r = cpu_out_r;
  assign bus_m.cpu_done  = cpu_done;
  assign bus_t.rx_data   = rx_data;
  assign bus_t.rx_valid  = rx_valid & sel;
  assign bus_t.cpu_out_r = cpu_out_r;
  assign bus_t.cpu_done  = cpu_done;
  assign cur_ready       = sel ? bus_t.rx_ready : bus_m.rx_ready;

  cpu_prog_loader dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  cpu_prog_loader #(.MAX_CYCLES(8)) dut_t (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_t)
  );

  always #5 clk = ~clk;

  // Write/pulse logging and invariant monitoring, sampled mid-cycle.
  logic [7:0]  ilog_a [1024];
  logic [15:0] ilog_d [1024];
  logic [7:0]  dlog_a [1024];
  logic [15:0] dlog_d [1024];
  int icnt  = 0;
  int dcnt  = 0;
  int ovcnt = 0;
  int viol  = 0;

  always @(negedge clk) begin
    if (bus_m.ex_iwe) begin
      if (icnt < 1024) begin
        ilog_a[icnt] = bus_m.ex_iaddr;
        ilog_d[icnt] = bus_m.ex_idata;
      end
      icnt++;
    end
    if (bus_m.ex_dwe) begin
      if (dcnt < 1024) begin
        dlog_a[dcnt] = bus_m.ex_daddr;
        dlog_d[dcnt] = bus_m.ex_ddata;
      end
      dcnt++;
    end
    if (bus_m.out_valid) ovcnt++;
    if (bus_m.ex_iwe && bus_m.ex_dwe) viol++;
    if ((bus_m.ex_iwe || bus_m.ex_dwe) && bus_m.cpu_rst_n) viol++;
    if (bus_t.ex_iwe && bus_t.ex_dwe) viol++;
    if ((bus_t.ex_iwe || bus_t.ex_dwe) && bus_t.cpu_rst_n) viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!cur_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("send_stall", 32'(n), 32'd0);
    tick();
    rx_valid = 1'b0;
  endtask

  int ib, db, ob, errs;

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cpu_out_r = 16'h0000;
    cpu_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check_eq("rst_rx_ready", 32'(bus_m.rx_ready), 32'd1);
    check_eq("rst_busy", 32'(bus_m.busy), 32'd0);
    check_eq("rst_cpu_rst_n", 32'(bus_m.cpu_rst_n), 32'd0);
    check_eq("rst_we", {30'd0, bus_m.ex_iwe, bus_m.ex_dwe}, 32'd0);
    check_eq("rst_flags", {28'd0, bus_m.run_done, bus_m.timeout, bus_m.cmd_err,
                           bus_m.out_valid}, 32'd0);
    check_eq("rst_out_data", 32'(bus_m.out_data), 32'd0);
    check_eq("rst_cycle_count", 32'(bus_m.cycle_count), 32'd0);

    // Instruction load: two words at 0x10
    ib = icnt;
    db = dcnt;
    send_byte(8'h49);
    check_eq("i_busy", 32'(bus_m.busy), 32'd1);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    check_eq("i_strobe_now", 32'(bus_m.ex_iwe), 32'd1);
    check_eq("i_ready_in_write", 32'(bus_m.rx_ready), 32'd0);
    tick();
    check_eq("i_strobe_gone", 32'(bus_m.ex_iwe), 32'd0);
    check_eq("i_busy_after", 32'(bus_m.busy), 32'd0);
    tick();
    check_eq("i_count", 32'(icnt - ib), 32'd2);
    check_eq("i_w0", {ilog_a[ib], ilog_d[ib]}, 32'h0010_1234 & 32'h00FF_FFFF);
    check_eq("i_w1", {ilog_a[ib+1], ilog_d[ib+1]}, 32'h0011_ABCD & 32'h00FF_FFFF);
    check_eq("i_no_dwe", 32'(dcnt - db), 32'd0);
    check_eq("i_addr_hold", 32'(bus_m.ex_iaddr), 32'h11);

    // Data load with address wrap
    ib = icnt;
    db = dcnt;
    send_byte(8'h44);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    send_byte(8'h0D);
    repeat (2) tick();
    check_eq("d_count", 32'(dcnt - db), 32'd2);
    check_eq("d_w0", {dlog_a[db], dlog_d[db]}, 32'h00FF_0A0B);
    check_eq("d_w1_wrap", {dlog_a[db+1], dlog_d[db+1]}, 32'h0000_0C0D);
    check_eq("d_no_iwe", 32'(icnt - ib), 32'd0);

    // 256-word data load (COUNT=0)
    db = dcnt;
    send_byte(8'h44);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(8'(i) ^ 8'hA5);
    end
    repeat (2) tick();
    check_eq("d256_count", 32'(dcnt - db), 32'd256);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (dlog_a[db+i] !== 8'(i)) errs++;
      if (dlog_d[db+i] !== {8'(i), 8'(i) ^ 8'hA5}) errs++;
    end
    check_eq("d256_seq", 32'(errs), 32'd0);
    check_eq("d256_idle", 32'(bus_m.busy), 32'd0);

    // Run: Out_R=0x42 in cycle 5, halt in cycle 20
    ob = ovcnt;
    send_byte(8'h52);
    check_eq("run_cpu_rst_n", 32'(bus_m.cpu_rst_n), 32'd1);
    check_eq("run_ready", 32'(bus_m.rx_ready), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      cpu_out_r = (k == 5) ? 16'h0042 : 16'h0000;
      cpu_done  = (k == 20);
      if (k == 10) begin
        check_eq("run_mid_count", 32'(bus_m.cycle_count), 32'd9);
        check_eq("run_mid_rst_n", 32'(bus_m.cpu_rst_n), 32'd1);
      end
      tick();
    end
    cpu_out_r = 16'h0000;
    cpu_done  = 1'b0;
    check_eq("run_done", 32'(bus_m.run_done), 32'd1);
    check_eq("run_timeout", 32'(bus_m.timeout), 32'd0);
    check_eq("run_cycles", 32'(bus_m.cycle_count), 32'd20);
    check_eq("run_out_data", 32'(bus_m.out_data), 32'h42);
    check_eq("run_out_valid_n", 32'(ovcnt - ob), 32'd1);
    check_eq("run_cpu_rst_low", 32'(bus_m.cpu_rst_n), 32'd0);
    check_eq("run_busy_after", 32'(bus_m.busy), 32'd0);

    // Timeout on the MAX_CYCLES=8 instance, with a byte pending during RUN
    sel = 1'b1;
    send_byte(8'h52);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    errs = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus_t.rx_ready !== 1'b0) errs++;
      if (k == 8) check_eq("to_not_yet", 32'(bus_t.timeout), 32'd0);
      tick();
    end
    check_eq("to_ready_low", 32'(errs), 32'd0);
    check_eq("to_timeout", 32'(bus_t.timeout), 32'd1);
    check_eq("to_run_done", 32'(bus_t.run_done), 32'd0);
    check_eq("to_cycles", 32'(bus_t.cycle_count), 32'd8);
    check_eq("to_cpu_rst_n", 32'(bus_t.cpu_rst_n), 32'd0);
    tick();
    rx_valid = 1'b0;
    check_eq("bad_cmd_err", 32'(bus_t.cmd_err), 32'd1);
    check_eq("bad_cmd_clr_to", 32'(bus_t.timeout), 32'd0);
    check_eq("bad_cmd_idle", 32'(bus_t.busy), 32'd0);

    // Halt on the same cycle as the limit: halt wins
    send_byte(8'h52);
    check_eq("r_clears_err", 32'(bus_t.cmd_err), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cpu_done = (k == 8);
      tick();
    end
    cpu_done = 1'b0;
    check_eq("tie_run_done", 32'(bus_t.run_done), 32'd1);
    check_eq("tie_timeout", 32'(bus_t.timeout), 32'd0);
    sel = 1'b0;

    // Reset after HI byte: no write, next frame parses from CMD
    ib = icnt;
    send_byte(8'h49);
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h99);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("mid_rst_no_write", 32'(icnt - ib), 32'd0);
    check_eq("mid_rst_idle", 32'(bus_m.busy), 32'd0);
    send_byte(8'h49);
    send_byte(8'h30);
    send_byte(8'h01);
    send_byte(8'h56);
    send_byte(8'h78);
    repeat (2) tick();
    check_eq("post_rst_count", 32'(icnt - ib), 32'd1);
    check_eq("post_rst_w0", {ilog_a[ib], ilog_d[ib]}, 32'h0030_5678);

    check_eq("strobe_invariants", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
